// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the integer register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int ZERO_REG     = 0;

  // A one-entry file still needs a one-bit address port.
  function automatic int calc_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: writeback clears, issue sets, and set wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEFAULT,
  localparam int AW   = calc_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_a,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] r_busy;

  // Decoding only indices 1..NREG-1 keeps bit 0 and out-of-range addresses inert.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = ZERO_REG + 1; i < NREG; i++) begin
      w_set[i] = iss_v && (iss_a == AW'(i));
      w_clr[i] = (we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_2w_sb.sv
// Two-write, two-read integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_2w_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  parameter  int NREG = NREG_DEFAULT,
  localparam int AW   = calc_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rbusy1,
  output logic            rbusy2,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   wa0,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd0,
  input  logic [XLEN-1:0] wd1,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_a,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] w_busy_vec;
  logic [AW-1:0]   w_ra    [2];
  logic [XLEN-1:0] w_rd    [2];
  logic            w_rbusy [2];
  logic            w_wr0;
  logic            w_wr1;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != AW'(ZERO_REG)) && (int'(a) < NREG);
  endfunction

  regfile_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .iss_v    (iss_v),
    .iss_a    (iss_a),
    .busy_vec (w_busy_vec)
  );

  // Port 0 yields to port 1 when both target the same register.
  assign w_wr1 = we1 && addr_ok(wa1);
  assign w_wr0 = we0 && addr_ok(wa0) && !(we1 && (wa1 == wa0));

  // NOTE: the array is reset explicitly because architectural state must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
    end
  end

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p]    = '0;
      w_rbusy[p] = 1'b0;
      if (addr_ok(w_ra[p])) begin
        w_rd[p]    = r_mem[w_ra[p]];
        w_rbusy[p] = w_busy_vec[w_ra[p]];
`ifdef REGFILE_BYPASS_EN
        // A completing write forwards its data; only a same-cycle reissue keeps it busy.
        if (!rst && ((we1 && (wa1 == w_ra[p])) || (we0 && (wa0 == w_ra[p])))) begin
          w_rd[p]    = (we1 && (wa1 == w_ra[p])) ? wd1 : wd0;
          w_rbusy[p] = iss_v && (iss_a == w_ra[p]);
        end
`endif
      end
    end
  end

  assign rd1      = w_rd[0];
  assign rd2      = w_rd[1];
  assign rbusy1   = w_rbusy[0];
  assign rbusy2   = w_rbusy[1];
  assign busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Self-checking bench for regfile_2w_sb (NREG=24 to exercise out-of-range addresses).
module tb_regfile_2w_sb;

  localparam int XLEN = 32;
  localparam int NREG = 24;
  localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   ra1, ra2, wa0, wa1, iss_a;
  logic [XLEN-1:0] rd1, rd2, wd0, wd1;
  logic            rbusy1, rbusy2, we0, we1, iss_v;
  logic [NREG-1:0] busy_vec;

  int vectors     = 0;
  int miscompares = 0;

  logic [XLEN-1:0] m_mem [NREG];
  logic [NREG-1:0] m_busy;

  regfile_2w_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_v(iss_v), .iss_a(iss_a), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic bit in_rf(input logic [AW-1:0] a);
    return (a != 0) && (int'(a) < NREG);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (rst || !in_rf(a)) return '0;
    if (BYP && we1 && wa1 == a) return wd1;
    if (BYP && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    if (rst || !in_rf(a)) return 1'b0;
    if (BYP && ((we1 && wa1 == a) || (we0 && wa0 == a))) return iss_v && (iss_a == a);
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  // Advance one edge, apply the architectural rules to the model, settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (we0 && in_rf(wa0)) m_mem[wa0] = wd0;
      if (we1 && in_rf(wa1)) m_mem[wa1] = wd1;
      if (we0 && in_rf(wa0)) m_busy[wa0] = 1'b0;
      if (we1 && in_rf(wa1)) m_busy[wa1] = 1'b0;
      if (iss_v && in_rf(iss_a)) m_busy[iss_a] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_v = 0;
    wa0 = '0; wa1 = '0; iss_a = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic test_reset();
    idle(); ra1 = 5;
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_v = 1; iss_a = 6;
    tick(); idle(); #1;
    vectors++;
    if (rd1 !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL reset_prewrite_rd1: got %h want %h", rd1, 32'hDEADBEEF);
    end
    vectors++;
    if (busy_vec !== 24'h000040) begin
      miscompares++; $display("FAIL reset_prewrite_busy: got %h want %h", busy_vec, 24'h000040);
    end
    rst = 1; model_clear(); #1;
    vectors++;
    if (rd1 !== '0) begin
      miscompares++; $display("FAIL reset_async_rd1: got %h want 0", rd1);
    end
    vectors++;
    if (busy_vec !== '0) begin
      miscompares++; $display("FAIL reset_async_busy: got %h want 0", busy_vec);
    end
    we0 = 1; wa0 = 5; wd0 = 32'h1; iss_v = 1; iss_a = 5;
    tick(); rst = 0; idle(); #1;
    vectors++;
    if (rd1 !== '0 || rbusy1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_discard: got rd1=%h rbusy1=%b want 0/0", rd1, rbusy1);
    end
  endtask

  task automatic test_zero_reg();
    idle(); ra1 = 0;
    we0 = 1; wa0 = 0; wd0 = 32'h1234; iss_v = 1; iss_a = 0;
    tick(); idle(); #1;
    vectors++;
    if (rd1 !== '0 || busy_vec[0] !== 1'b0) begin
      miscompares++; $display("FAIL zero_reg: got rd1=%h busy0=%b want 0/0", rd1, busy_vec[0]);
    end
  endtask

  task automatic test_collision();
    idle(); ra1 = 7;
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    tick(); idle(); #1;
    vectors++;
    if (rd1 !== 32'h22) begin
      miscompares++; $display("FAIL collision: got %h want %h", rd1, 32'h22);
    end
  endtask

  task automatic test_scoreboard();
    idle(); ra1 = 9;
    iss_v = 1; iss_a = 9;
    tick(); idle(); #1;
    vectors++;
    if (busy_vec[9] !== 1'b1 || rbusy1 !== 1'b1) begin
      miscompares++; $display("FAIL sb_set: got busy9=%b rbusy1=%b want 1/1", busy_vec[9], rbusy1);
    end
    we1 = 1; wa1 = 9; wd1 = 32'hA5; iss_v = 1; iss_a = 9; #1;
    vectors++;
    if (rbusy1 !== 1'b1) begin
      miscompares++; $display("FAIL sb_reissue_rbusy: got %b want 1", rbusy1);
    end
    tick(); idle(); #1;
    vectors++;
    if (busy_vec[9] !== 1'b1 || rd1 !== 32'hA5) begin
      miscompares++; $display("FAIL sb_set_wins: got busy9=%b rd1=%h want 1/a5", busy_vec[9], rd1);
    end
    we0 = 1; wa0 = 9; wd0 = 32'h5A;
    tick(); idle(); #1;
    vectors++;
    if (busy_vec[9] !== 1'b0 || rd1 !== 32'h5A) begin
      miscompares++; $display("FAIL sb_clear: got busy9=%b rd1=%h want 0/5a", busy_vec[9], rd1);
    end
  endtask

  task automatic test_bypass();
    idle(); ra2 = 3;
    we0 = 1; wa0 = 3; wd0 = 32'h77; iss_v = 1; iss_a = 3;
    tick(); idle();
    we0 = 1; wa0 = 3; wd0 = 32'h55; #1;
    vectors++;
    if (rd2 !== (BYP ? 32'h55 : 32'h77)) begin
      miscompares++; $display("FAIL bypass_rd2: got %h want %h", rd2, BYP ? 32'h55 : 32'h77);
    end
    vectors++;
    if (rbusy2 !== !BYP) begin
      miscompares++; $display("FAIL bypass_rbusy2: got %b want %b", rbusy2, !BYP);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd2 !== 32'h55 || busy_vec[3] !== 1'b0) begin
      miscompares++; $display("FAIL bypass_next: got rd2=%h busy3=%b want 55/0", rd2, busy_vec[3]);
    end
  endtask

  task automatic test_out_of_range();
    idle(); ra1 = 30; ra2 = 23;
    we0 = 1; wa0 = 23; wd0 = 32'hC0FFEE; iss_v = 1; iss_a = 23;
    tick(); idle();
    we0 = 1; wa0 = 30; wd0 = 32'hBAD0; we1 = 1; wa1 = 24; wd1 = 32'hBAD1;
    iss_v = 1; iss_a = 31; #1;
    vectors++;
    if (rd1 !== '0 || rbusy1 !== 1'b0) begin
      miscompares++; $display("FAIL oor_read: got rd1=%h rbusy1=%b want 0/0", rd1, rbusy1);
    end
    tick(); idle(); #1;
    vectors++;
    if (busy_vec !== m_busy) begin
      miscompares++; $display("FAIL oor_busy: got %h want %h", busy_vec, m_busy);
    end
    vectors++;
    if (rd2 !== 32'hC0FFEE || rbusy2 !== 1'b1) begin
      miscompares++; $display("FAIL top_reg: got rd2=%h rbusy2=%b want c0ffee/1", rd2, rbusy2);
    end
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (rst) model_clear();
      we0 = $urandom_range(0, 1); wa0 = AW'($urandom_range(0, 31)); wd0 = $urandom;
      we1 = $urandom_range(0, 1); wa1 = AW'($urandom_range(0, 31)); wd1 = $urandom;
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      iss_v = $urandom_range(0, 1); iss_a = AW'($urandom_range(0, 31));
      ra1 = AW'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 1) == 1) ? wa0 : AW'($urandom_range(0, 31));
      #1;
      vectors++;
      if (rd1 !== exp_rd(ra1) || rbusy1 !== exp_rbusy(ra1)) begin
        miscompares++;
        $display("FAIL rand_port1 c=%0d ra1=%0d: got %h/%b want %h/%b",
                 c, ra1, rd1, rbusy1, exp_rd(ra1), exp_rbusy(ra1));
      end
      vectors++;
      if (rd2 !== exp_rd(ra2) || rbusy2 !== exp_rbusy(ra2)) begin
        miscompares++;
        $display("FAIL rand_port2 c=%0d ra2=%0d: got %h/%b want %h/%b",
                 c, ra2, rd2, rbusy2, exp_rd(ra2), exp_rbusy(ra2));
      end
      tick();
      vectors++;
      if (busy_vec !== m_busy) begin
        miscompares++; $display("FAIL rand_busy c=%0d: got %h want %h", c, busy_vec, m_busy);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1; idle(); ra1 = 0; ra2 = 0; model_clear();
    #2;
    vectors++;
    if (rd1 !== '0 || rd2 !== '0 || rbusy1 !== 1'b0 || rbusy2 !== 1'b0 || busy_vec !== '0) begin
      miscompares++;
      $display("FAIL initial_reset: got rd1=%h rd2=%h rb=%b%b busy=%h want zeros",
               rd1, rd2, rbusy1, rbusy2, busy_vec);
    end
    @(posedge clk); #1; rst = 0;
    test_reset();
    test_zero_reg();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_out_of_range();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_2w_sb.md
# regfile_2w_sb

Parametrised integer register file with two write ports, two combinational read ports and a per-register busy scoreboard. It is the next-generation general-purpose register file for the CPU core. Decode marks a destination busy at issue. Writeback ports clear the busy flag when they deliver the result. An optional write-to-read bypass lets a value written this cycle be read in the same cycle.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (2..64; need not be a power of two)
- AW, $clog2(NREG), address width (derived; not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data
- rbusy1, rbusy2  out  1  busy flag of ra1/ra2
- we0, we1  in  1  write enables; port 1 has priority
- wa0, wa1  in  AW  write addresses
- wd0, wd1  in  XLEN  write data
- iss_v  in  1  issue strobe: mark iss_a busy
- iss_a  in  AW  destination address being issued
- busy_vec  out  NREG  registered scoreboard, bit i = register i busy

## Operation
- Register 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - rd returns 0 for address 0.
  - Busy bit 0 is never set; busy_vec[0] is always 0.
- Addresses ≥ NREG are out of range.
  - Writes and issues to them are ignored.
  - Reads return 0 with busy 0.
- Write rules:
  - Each enabled port writes its data at the clock edge.
  - If we0 and we1 are both set and wa0 == wa1, port 1's data is stored. Port 0's write is dropped.
- Scoreboard rules, evaluated per register at each edge:
  - An enabled write to address a clears busy[a].
  - iss_v to address a sets busy[a].
  - If a set and a clear hit the same address in the same cycle, the set wins: a new producer is issued behind the completing one.
  - A write to a non-busy register is legal. It updates the data, and busy stays 0.
- Reads are combinational from ra1/ra2.
  - rbusy reflects busy_vec, or the bypassed value when REGFILE_BYPASS_EN is defined (see Configuration).
- Reset:
  - All registers are cleared to 0 and busy_vec to 0.
  - Consequently rd1 = rd2 = 0 and rbusy1 = rbusy2 = 0 while rst is high.
  - Reset asserted mid-operation discards any writes and issues in that cycle.

## Timing
- Read data latency: 0 cycles (combinational).
- Write visibility:
  - Without bypass, data is readable from the cycle after the write.
  - With bypass, data is readable in the same cycle.
- Busy: set or clear is visible on busy_vec one cycle after the iss_v or we cycle.
- No handshake, no stall; every write and issue is accepted in the cycle presented.
- Reset is asynchronous assert. Deassertion must be synchronised externally to clk.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined:
  - If ra matches an enabled write address that is nonzero and in range, rd returns that port's wd. Port 1 wins if both ports match.
  - In that case rbusy returns 0, unless iss_v targets the same address this cycle, in which case it returns 1.
- Undefined:
  - rd returns the stored value and rbusy returns busy_vec[ra].
  - The bypass mux logic is absent.

## Structure
- Package regfile_pkg holds:
  - default XLEN and NREG;
  - the AW derivation function;
  - localparam ZERO_REG = 0.
- One sub-module, regfile_scoreboard.
  - Holds the NREG-bit busy vector with the set/clear priority logic.
  - Inputs: we0/wa0, we1/wa1, iss_v/iss_a.
  - Output: busy_vec.
- The data array and the read/bypass muxing stay in the top module.

## Test plan
- Reset:
  - Write 0xDEADBEEF to r5, then pulse rst.
  - Expect rd1(ra1=5) = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
- Zero register:
  - we0, wa0=0, wd0=0x1234, together with iss_v, iss_a=0.
  - Next cycle: rd1(ra1=0) = 0 and busy_vec[0] = 0.
- Dual-write collision:
  - we0/we1 both to r7, wd0=0x11, wd1=0x22.
  - Next cycle rd1 = 0x22.
- Scoreboard:
  - Cycle 1: iss_v r9. Cycle 2: busy_vec[9] = 1.
  - Cycle 3: we1 r9, wd1=0xA5, together with iss_v r9.
  - Cycle 4: busy_vec[9] = 1 and rd = 0xA5.
- Bypass:
  - we0 r3, wd0=0x55 with ra2=3 in the same cycle.
  - With REGFILE_BYPASS_EN: rd2 = 0x55 and rbusy2 = 0 that cycle.
  - Without it: old value that cycle, 0x55 the next cycle.
- Out of range (NREG=24):
  - Write to address 30.
  - Expect busy_vec unchanged and rd(ra=30) = 0.
